// File: rtl/pmu_counter_bank.sv
// PMU event counter bank: one counter per event bit, with load, sticky overflow and irq.
// Optional overflow interrupt is built when PMU_OVF_IRQ_EN is defined; otherwise irq_o is 0.
module pmu_counter_bank #(
    parameter int N_COUNTERS = 24,
    parameter int REG_WIDTH  = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [N_COUNTERS-1:0]           events_i,
    input  logic                            en_i,
    input  logic                            softrst_i,
    input  logic [N_COUNTERS-1:0]           we_i,
    input  logic [N_COUNTERS*REG_WIDTH-1:0] wdata_i,
    input  logic [N_COUNTERS-1:0]           ovf_clr_i,
    input  logic [N_COUNTERS-1:0]           ovf_mask_i,
    output logic [N_COUNTERS*REG_WIDTH-1:0] counter_o,
    output logic [N_COUNTERS-1:0]           ovf_o,
    output logic                            irq_o
);

    localparam logic [REG_WIDTH-1:0] ONE = 1;

    logic [N_COUNTERS-1:0][REG_WIDTH-1:0] cnt_q;
    logic [N_COUNTERS-1:0][REG_WIDTH-1:0] cnt_d;
    logic [N_COUNTERS-1:0]                ovf_q;
    logic [N_COUNTERS-1:0]                ovf_d;
    logic [N_COUNTERS-1:0]                inc;
    logic [N_COUNTERS-1:0]                wrap;

    // Next-state per counter: load beats increment; a wrap sets the flag over a clear.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        inc   = '0;
        wrap  = '0;
        for (int k = 0; k < N_COUNTERS; k++) begin
            inc[k]  = en_i & events_i[k] & ~we_i[k];
            wrap[k] = inc[k] & (&cnt_q[k]);
            if (we_i[k]) begin
                cnt_d[k] = wdata_i[k*REG_WIDTH +: REG_WIDTH];
            end else if (inc[k]) begin
                cnt_d[k] = cnt_q[k] + ONE;
            end
            if (wrap[k]) begin
                ovf_d[k] = 1'b1;
            end else if (ovf_clr_i[k]) begin
                ovf_d[k] = 1'b0;
            end
        end
    end

    // Counter and flag registers; softrst clears everything ahead of loads and events.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= '0;
        end else if (softrst_i) begin
            cnt_q <= '0;
            ovf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign counter_o = cnt_q;
    assign ovf_o     = ovf_q;

`ifdef PMU_OVF_IRQ_EN
    logic irq_q;

    // Interrupt follows the registered flags one cycle later, gated by the mask.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
        end else if (softrst_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(ovf_q & ovf_mask_i);
        end
    end

    assign irq_o = irq_q;
`else
    logic unused_mask;

    assign unused_mask = ^ovf_mask_i;
    assign irq_o       = 1'b0;
`endif

endmodule

// File: tb/tb_pmu_counter_bank.sv
// Self-checking bench for pmu_counter_bank (N_COUNTERS=4, REG_WIDTH=8).
// Directed scenarios followed by randomized traffic against a behavioural model.
module tb_pmu_counter_bank;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   events;
    logic           en;
    logic           softrst;
    logic [N-1:0]   we;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   ovf_clr;
    logic [N-1:0]   mask;
    logic [N*W-1:0] counter;
    logic [N-1:0]   ovf;
    logic           irq;

    int        m_cnt [N];
    bit [N-1:0] m_ovf;
    bit        m_irq;
    int        total = 0;
    int        bad   = 0;

    pmu_counter_bank #(.N_COUNTERS(N), .REG_WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .events_i   (events),
        .en_i       (en),
        .softrst_i  (softrst),
        .we_i       (we),
        .wdata_i    (wdata),
        .ovf_clr_i  (ovf_clr),
        .ovf_mask_i (mask),
        .counter_o  (counter),
        .ovf_o      (ovf),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    function automatic bit irq_built();
`ifdef PMU_OVF_IRQ_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_cnt(input string tag, input int k, input int exp);
        logic [W-1:0] got;
        got = counter[k*W +: W];
        total++;
        assert (got === W'(exp))
        else begin
            bad++;
            $error("FAIL %s cnt%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic check_ovf(input string tag, input logic [N-1:0] exp);
        total++;
        assert (ovf === exp)
        else begin
            bad++;
            $error("FAIL %s ovf got=%b exp=%b", tag, ovf, exp);
        end
    endtask

    task automatic check_irq(input string tag, input logic exp);
        total++;
        assert (irq === exp)
        else begin
            bad++;
            $error("FAIL %s irq got=%b exp=%b", tag, irq, exp);
        end
    endtask

    task automatic check_model(input string tag);
        for (int k = 0; k < N; k++) check_cnt(tag, k, m_cnt[k]);
        check_ovf(tag, m_ovf);
        check_irq(tag, m_irq);
    endtask

    // Advance the model by one clock using the current inputs, then compare after the edge.
    task automatic tick(input string tag);
        bit [N-1:0] old_ovf;
        old_ovf = m_ovf;
        if (rst || softrst) begin
            for (int k = 0; k < N; k++) m_cnt[k] = 0;
            m_ovf = '0;
            m_irq = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (we[k]) begin
                    m_cnt[k] = int'(wdata[k*W +: W]);
                    if (ovf_clr[k]) m_ovf[k] = 1'b0;
                end else if (en && events[k]) begin
                    if (m_cnt[k] == (1 << W) - 1) m_ovf[k] = 1'b1;
                    else if (ovf_clr[k]) m_ovf[k] = 1'b0;
                    m_cnt[k] = (m_cnt[k] + 1) % (1 << W);
                end else if (ovf_clr[k]) begin
                    m_ovf[k] = 1'b0;
                end
            end
            m_irq = irq_built() && ((old_ovf & mask) != '0);
        end
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic idle_inputs();
        events  = '0;
        we      = '0;
        wdata   = '0;
        ovf_clr = '0;
        softrst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
        m_ovf = '0;
        m_irq = 1'b0;
        idle_inputs();
        mask   = '0;
        rst    = 1'b1;
        en     = 1'b1;
        events = 4'hF;

        // Reset held with events active: everything stays zero.
        repeat (3) tick("reset_hold");
        rst = 1'b0;
        repeat (5) tick("after_reset");
        for (int k = 0; k < N; k++) check_cnt("reset_five", k, 5);

        // Count with enable, then freeze.
        softrst = 1'b1;
        tick("clear");
        softrst = 1'b0;
        events  = 4'b0101;
        repeat (10) tick("count");
        en = 1'b0;
        repeat (3) tick("frozen");
        check_cnt("en_hold", 0, 10);
        check_cnt("en_hold", 1, 0);
        check_cnt("en_hold", 2, 10);
        check_cnt("en_hold", 3, 0);

        // Wrap on counter 1.
        en     = 1'b1;
        events = '0;
        we     = 4'b0010;
        wdata  = 32'h0000_FE00;
        tick("load_fe");
        we     = '0;
        events = 4'b0010;
        tick("to_ff");
        check_cnt("wrap_ff", 1, 8'hFF);
        tick("wrap");
        check_cnt("wrap_00", 1, 0);
        check_ovf("wrap_flag", 4'b0010);
        events = '0;
        mask   = 4'b0010;
        tick("irq_rise");
        check_irq("irq_rise", irq_built());
        ovf_clr = 4'b0010;
        mask    = 4'b1000;
        tick("clr1");
        ovf_clr = '0;
        tick("clr1_settle");

        // Load beats a same-cycle event.
        we     = 4'b0100;
        wdata  = 32'h0040_0000;
        events = 4'b0100;
        tick("load_vs_event");
        check_cnt("load_wins", 2, 8'h40);

        // Wrap beats a same-cycle flag clear.
        events = '0;
        we     = 4'b1000;
        wdata  = 32'hFF00_0000;
        tick("load_ff3");
        we      = '0;
        events  = 4'b1000;
        ovf_clr = 4'b1000;
        tick("wrap_vs_clr");
        check_ovf("set_wins", 4'b1000);
        events  = '0;
        ovf_clr = '0;
        tick("irq3");
        check_irq("irq3_up", irq_built());
        ovf_clr = 4'b1000;
        tick("clr3");
        check_ovf("clr3", 4'b0000);
        ovf_clr = '0;
        tick("irq3_drop");
        check_irq("irq3_drop", 1'b0);

        // softrst overrides loads, with all flags and irq up.
        we    = 4'hF;
        wdata = 32'hFFFF_FFFF;
        tick("load_all_ff");
        we     = '0;
        events = 4'hF;
        mask   = 4'hF;
        tick("wrap_all");
        events = '0;
        we     = 4'hF;
        wdata  = 32'h3333_3333;
        tick("load_33");
        we = '0;
        check_ovf("all_flags", 4'hF);
        tick("irq_all");
        softrst = 1'b1;
        we      = 4'hF;
        wdata   = 32'h5555_5555;
        tick("softrst");
        for (int k = 0; k < N; k++) check_cnt("softrst", k, 0);
        check_ovf("softrst", 4'h0);
        check_irq("softrst", 1'b0);
        idle_inputs();

        // Flag set with mask off never raises irq.
        mask  = '0;
        we    = 4'b0001;
        wdata = 32'h0000_00FF;
        tick("load_ff0");
        we     = '0;
        events = 4'b0001;
        tick("wrap0");
        events = '0;
        repeat (2) tick("masked");
        check_ovf("masked_flag", 4'b0001);
        check_irq("masked_irq", 1'b0);

        // Randomized traffic with one asynchronous reset in the middle.
        for (int i = 0; i < 400; i++) begin
            events  = 4'($urandom);
            en      = ($urandom_range(0, 7) != 0);
            softrst = ($urandom_range(0, 60) == 0);
            we      = 4'($urandom) & 4'($urandom) & 4'($urandom);
            for (int k = 0; k < N; k++) begin
                case ($urandom_range(0, 3))
                    0: wdata[k*W +: W] = 8'hFF;
                    1: wdata[k*W +: W] = 8'hFE;
                    default: wdata[k*W +: W] = 8'($urandom);
                endcase
            end
            ovf_clr = 4'($urandom) & 4'($urandom);
            mask    = 4'($urandom);
            if (i == 200) begin
                rst = 1'b1;
                #1;
                for (int k = 0; k < N; k++) check_cnt("async_rst", k, 0);
                check_ovf("async_rst", 4'h0);
                check_irq("async_rst", 1'b0);
                tick("rst_mid");
                rst = 1'b0;
            end
            tick("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
